// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-addressed, synchronous-read data
// memory. It accepts one load/store at a time from EX, drives MemRead/MemWrite,
// and returns sign- or zero-extended load data. Byte and halfword stores are
// done as read-modify-write because the memory has no byte enables.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/SH and W/SW complete with resp_err, no access
//   undefined -> low address bits below the access size are ignored
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_store, req_funct3          op kind and RISC-V size/sign code
//   req_addr, req_wdata            byte address, store data
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_err           extended load data, error flag
//   MemRead, MemWrite              memory strobes (registered)
//   Addr, WriteData                word index and write word (registered)
//   ReadData                       memory data, valid the cycle after MemRead
module load_store_unit #(
    parameter int unsigned Width  = 32,
    parameter int unsigned MEM_AW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [Width-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [Width-1:0] resp_rdata,
    output logic             resp_err,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [Width-1:0] Addr,
    output logic [Width-1:0] WriteData,
    input  logic [Width-1:0] ReadData
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched request fields needed after acceptance
    logic        op_store_q, op_store_d;
    logic [2:0]  op_funct3_q, op_funct3_d;
    logic [1:0]  op_lo_q, op_lo_d;
    logic [15:0] op_wdata_q, op_wdata_d;

    logic [Width-1:0] resp_rdata_d;
    logic             resp_err_d;
    logic [Width-1:0] addr_d;
    logic [Width-1:0] wdata_d;

    logic             req_illegal_c;
    logic             req_misalign_c;
    logic [7:0]       rd_byte_c;
    logic [15:0]      rd_half_c;
    logic [Width-1:0] load_ext_c;
    logic [Width-1:0] merged_c;

    // Address bits above the memory and the unused upper store bytes
    logic unused_bits;
    assign unused_bits = ^{req_addr[Width-1:MEM_AW+2], req_wdata[Width-1:16]};

    // Request classification: illegal size codes and, optionally, misalignment
    always_comb begin
        req_illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_misalign_c = 1'b0;
`endif
    end

    // Load lane select/extend and store lane merge on the returned word
    always_comb begin
        rd_byte_c = 8'(ReadData >> {op_lo_q, 3'b000});
        rd_half_c = op_lo_q[1] ? ReadData[31:16] : ReadData[15:0];
        case (op_funct3_q)
            3'b000:  load_ext_c = {{(Width-8){rd_byte_c[7]}}, rd_byte_c};
            3'b001:  load_ext_c = {{(Width-16){rd_half_c[15]}}, rd_half_c};
            3'b100:  load_ext_c = Width'(rd_byte_c);
            3'b101:  load_ext_c = Width'(rd_half_c);
            default: load_ext_c = ReadData;
        endcase
        merged_c = ReadData;
        if (op_funct3_q[0]) begin
            merged_c[{op_lo_q[1], 4'b0000} +: 16] = op_wdata_q;
        end else begin
            merged_c[{op_lo_q, 3'b000} +: 8] = op_wdata_q[7:0];
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d      = state_q;
        op_store_d   = op_store_q;
        op_funct3_d  = op_funct3_q;
        op_lo_d      = op_lo_q;
        op_wdata_d   = op_wdata_q;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        addr_d       = Addr;
        wdata_d      = WriteData;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_store_d   = req_store;
                    op_funct3_d  = req_funct3;
                    op_lo_d      = req_addr[1:0];
                    op_wdata_d   = req_wdata[15:0];
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    addr_d       = Width'(req_addr[MEM_AW+1:2]);
                    if (req_illegal_c || req_misalign_c) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
                        wdata_d = req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = CAP;
            CAP: begin
                if (op_store_q) begin
                    wdata_d = merged_c;
                    state_d = WR;
                end else begin
                    resp_rdata_d = load_ext_c;
                    state_d      = RESP;
                end
            end
            WR:   state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs; strobes follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            Addr        <= '0;
            WriteData   <= '0;
            op_store_q  <= 1'b0;
            op_funct3_q <= 3'b000;
            op_lo_q     <= 2'b00;
            op_wdata_q  <= 16'h0000;
        end else begin
            req_ready   <= (state_d == IDLE);
            resp_valid  <= (state_d == RESP);
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
            MemRead     <= (state_d == RD);
            MemWrite    <= (state_d == WR);
            Addr        <= addr_d;
            WriteData   <= wdata_d;
            op_store_q  <= op_store_d;
            op_funct3_q <= op_funct3_d;
            op_lo_q     <= op_lo_d;
            op_wdata_q  <= op_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives directed load/store requests into load_store_unit,
// attaches a 512-word synchronous-read memory, and checks every cycle against a
// transaction-level model (expected strobe cycles, address, write word, and
// response) plus hand-computed literal results.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    always #5 clk = ~clk;

    load_store_unit #(.Width(32), .MEM_AW(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .ReadData   (ReadData)
    );

    // Data memory seen by the DUT
    logic [31:0] tb_mem [0:511];
    always @(posedge clk) begin
        if (MemRead)  ReadData <= tb_mem[Addr[8:0]];
        if (MemWrite) tb_mem[Addr[8:0]] <= WriteData;
    end

    // Model's own view of memory contents
    logic [31:0] ref_mem [0:511];

    int checks = 0;
    int errors = 0;
    int cyc_count = 0;
    int wr_seen = 0;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Current transaction expectations (cycle offsets from the accept edge)
    logic        txn_active = 1'b0;
    int          txn_start = 0;
    int          exp_rd_at, exp_wr_at, exp_resp_at;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3[2]) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'b010 && (a % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned w,
                                               input int unsigned boff, input int unsigned hoff);
        int unsigned b, h;
        b = (w >> (8 * boff)) & 32'hFF;
        h = (w >> (16 * hoff)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_start(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int unsigned idx, boff, hoff, w, mask;
        idx  = (a / 4) % 512;
        boff = a % 4;
        hoff = (a / 2) % 2;
        w    = ref_mem[idx];
        exp_addr  = idx;
        exp_err   = model_err(st, f3, a);
        exp_rdata = 32'h0;
        exp_wdata = 32'h0;
        exp_rd_at = -1;
        exp_wr_at = -1;
        if (exp_err) begin
            exp_resp_at = 1;
        end else if (!st) begin
            exp_rd_at   = 1;
            exp_resp_at = 3;
            exp_rdata   = model_load(f3, w, boff, hoff);
        end else if (f3 == 3'b010) begin
            exp_wr_at   = 1;
            exp_resp_at = 2;
            exp_wdata   = wd;
        end else begin
            exp_rd_at   = 1;
            exp_wr_at   = 3;
            exp_resp_at = 4;
            if (f3 == 3'b000) begin
                mask      = 32'hFF << (8 * boff);
                exp_wdata = (w & ~mask) | ((wd & 32'hFF) << (8 * boff));
            end else begin
                mask      = 32'hFFFF << (16 * hoff);
                exp_wdata = (w & ~mask) | ((wd & 32'hFFFF) << (16 * hoff));
            end
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int k;
        if (MemWrite) wr_seen++;
        if (!rst_n) begin
            chk("rst_MemRead",    32'(MemRead),    32'h0);
            chk("rst_MemWrite",   32'(MemWrite),   32'h0);
            chk("rst_resp_valid", 32'(resp_valid), 32'h0);
            chk("rst_resp_err",   32'(resp_err),   32'h0);
            chk("rst_Addr",       Addr,            32'h0);
            chk("rst_WriteData",  WriteData,       32'h0);
            chk("rst_resp_rdata", resp_rdata,      32'h0);
        end else if (txn_active) begin
            k = cyc_count - txn_start;
            chk("req_ready",  32'(req_ready),  32'(k == 0));
            chk("MemRead",    32'(MemRead),    32'(k == exp_rd_at));
            chk("MemWrite",   32'(MemWrite),   32'(k == exp_wr_at));
            chk("resp_valid", 32'(resp_valid), 32'(k >= exp_resp_at));
            if (k == exp_rd_at || k == exp_wr_at) chk("Addr", Addr, exp_addr);
            if (k == exp_wr_at) chk("WriteData", WriteData, exp_wdata);
            if (k >= exp_resp_at) begin
                chk("resp_rdata", resp_rdata,      exp_rdata);
                chk("resp_err",   32'(resp_err),   32'(exp_err));
            end
        end else begin
            chk("idle_MemRead",    32'(MemRead),    32'h0);
            chk("idle_MemWrite",   32'(MemWrite),   32'h0);
            chk("idle_resp_valid", 32'(resp_valid), 32'h0);
            chk("idle_req_ready",  32'(req_ready),  32'h1);
        end
    end

    // Issue one request; hold resp_ready low for 'hold' cycles after the
    // response is due; with 'poke', present another request while busy.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int hold, input logic poke);
        logic got;
        model_start(st, f3, a, wd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        txn_start  = cyc_count;
        txn_active = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (poke) begin
            req_store  = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h0000_0040;
            req_valid  = 1'b1;
        end
        repeat (exp_resp_at + hold - 1) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_err   = resp_err;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no resp_valid, expected one within 8 cycles");
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        txn_active = 1'b0;
        if (st && !exp_err) ref_mem[exp_addr] = exp_wdata;
    endtask

    // Byte store interrupted by reset while the read word is being merged
    task automatic run_abort(input logic [31:0] a, input logic [31:0] wd);
        model_start(1'b1, 3'b000, a, wd);
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        txn_start  = cyc_count;
        txn_active = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b0;
        txn_active = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected one before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        for (int i = 0; i < 512; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_req_ready",  32'(req_ready), 32'h1);
        chk("reset_resp_rdata", resp_rdata,     32'h0);

        run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        chk("sw_mem_word4", tb_mem[4], 32'hDEADBEEF);
        run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        chk("lw_0x10", last_rdata, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0);
        chk("lb_0x13", last_rdata, 32'hFFFFFFDE);
        run_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0);
        chk("lbu_0x13", last_rdata, 32'h000000DE);
        run_txn(1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b0);
        chk("lh_0x12", last_rdata, 32'hFFFFDEAD);
        run_txn(1'b0, 3'b101, 32'h10, 32'h0, 0, 1'b0);
        chk("lhu_0x10", last_rdata, 32'h0000BEEF);

        run_txn(1'b1, 3'b000, 32'h11, 32'h00000055, 0, 1'b0);
        chk("sb_mem_word4", tb_mem[4], 32'hDEAD55EF);
        run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        chk("lw_after_sb", last_rdata, 32'hDEAD55EF);

        run_txn(1'b0, 3'b010, 32'h12, 32'h0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_0x12_err", 32'(last_err), 32'h1);
`else
        chk("lw_0x12_data", last_rdata, 32'hDEAD55EF);
`endif
        run_txn(1'b0, 3'b010, 32'h810, 32'h0, 0, 1'b0);
        chk("lw_wrap_0x810", last_rdata, 32'hDEAD55EF);

        run_txn(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1);
        chk("lw_stall", last_rdata, 32'hDEAD55EF);

        run_txn(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0);
        chk("f3_011_err", 32'(last_err), 32'h1);
        chk("f3_011_rdata", last_rdata, 32'h0);
        run_txn(1'b1, 3'b100, 32'h10, 32'h77, 0, 1'b0);
        chk("store_f3_100_err", 32'(last_err), 32'h1);
        chk("store_f3_100_mem", tb_mem[4], 32'hDEAD55EF);

        run_txn(1'b1, 3'b010, 32'h20, 32'h11223344, 0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 0, 1'b0);
        chk("sh_mem_word8", tb_mem[8], 32'hABCD3344);
        run_txn(1'b0, 3'b001, 32'h22, 32'h0, 0, 1'b0);
        chk("lh_0x22", last_rdata, 32'hFFFFABCD);
        run_txn(1'b0, 3'b100, 32'h21, 32'h0, 0, 1'b0);
        chk("lbu_0x21", last_rdata, 32'h00000033);
        run_txn(1'b0, 3'b000, 32'h20, 32'h0, 0, 1'b0);
        chk("lb_0x20", last_rdata, 32'h00000044);
        run_txn(1'b0, 3'b001, 32'h23, 32'h0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_0x23_err", 32'(last_err), 32'h1);
`else
        chk("lh_0x23_data", last_rdata, 32'hFFFFABCD);
`endif

        wr_before = wr_seen;
        run_abort(32'h10, 32'h000000AA);
        chk("abort_no_write", 32'(wr_seen), 32'(wr_before));
        chk("abort_mem_word4", tb_mem[4], 32'hDEAD55EF);
        run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        chk("lw_after_abort", last_rdata, 32'hDEAD55EF);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
